// File: rtl/sort_stat_engine.sv
// Purpose: collects a frame of n unsigned samples, then streams sum, min, max and the sorted samples.
// Latency: first out_valid one cycle after the edge accepting the n-th sample; n+3 output cycles.
// Backpressure: none; in_valid is dropped while outputting, and a bad frame length pulses err.
module sort_stat_engine #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 8,
    parameter int SUM_W  = DATA_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        data_num,
    input  logic              desc,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              out_valid,
    output logic [SUM_W-1:0]  result,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        OUT_SUM,
        OUT_MIN,
        OUT_MAX,
        OUT_DATA
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        n_q, cnt_q, idx_q, idx_nxt, cnt_eff;
    logic              desc_q;
    logic [SUM_W-1:0]  sum_q, sum_add, result_nxt;
    logic [DATA_W-1:0] sbuf [MAX_N];
    logic [DATA_W-1:0] nbuf [MAX_N];
    logic [MAX_N-1:0]  keep;
    logic [DATA_W-1:0] first_val, last_val, sel_val, min_val, max_val;
    logic              start, accept, err_nxt;

    // A frame start always inserts into an empty buffer, whatever the previous frame left behind.
    assign cnt_eff = start ? 4'd0 : cnt_q;
    assign sum_add = (start ? {SUM_W{1'b0}} : sum_q) + SUM_W'(data_in);

    // Single-cycle sorted insertion: slots whose value belongs before the new sample stay put
    // (equal values count as "before", which keeps insertion stable), the first other slot
    // takes the new sample, and everything behind it shifts one place.
    always_comb begin
        keep = '0;
        for (int i = 0; i < MAX_N; i++) begin
            keep[i] = (4'(i) < cnt_eff) &&
                      (desc_q ? (sbuf[i] >= data_in) : (sbuf[i] <= data_in));
        end
        nbuf[0] = keep[0] ? sbuf[0] : data_in;
        for (int i = 1; i < MAX_N; i++) begin
            nbuf[i] = keep[i] ? sbuf[i] : (keep[i-1] ? data_in : sbuf[i-1]);
        end
    end

    // Read muxes for the buffer ends (min/max) and the element being streamed out.
    always_comb begin
        first_val = sbuf[0];
        last_val  = sbuf[0];
        sel_val   = sbuf[0];
        for (int i = 0; i < MAX_N; i++) begin
            if (4'(i) == (n_q - 4'd1)) last_val = sbuf[i];
            if (4'(i) == idx_q)        sel_val  = sbuf[i];
        end
        min_val = desc_q ? last_val : first_val;
        max_val = desc_q ? first_val : last_val;
    end

    // Next-state logic; result_nxt is the value shown while in state_nxt, so result is registered.
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        accept     = 1'b0;
        err_nxt    = 1'b0;
        result_nxt = result;
        idx_nxt    = idx_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (data_num >= 4'd2 && data_num <= 4'(MAX_N)) begin
                        start     = 1'b1;
                        accept    = 1'b1;
                        state_nxt = COLLECT;
                    end else if (data_num == 4'd1) begin
                        start      = 1'b1;
                        accept     = 1'b1;
                        state_nxt  = OUT_SUM;
                        result_nxt = sum_add;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt_q + 4'd1 == n_q) begin
                        state_nxt  = OUT_SUM;
                        result_nxt = sum_add;
                    end
                end
            end
            OUT_SUM: begin
                state_nxt  = OUT_MIN;
                result_nxt = SUM_W'(min_val);
            end
            OUT_MIN: begin
                state_nxt  = OUT_MAX;
                result_nxt = SUM_W'(max_val);
            end
            OUT_MAX: begin
                state_nxt  = OUT_DATA;
                result_nxt = SUM_W'(first_val);
                idx_nxt    = 4'd1;
            end
            OUT_DATA: begin
                // idx_q counts elements already shown
                if (idx_q == n_q) begin
                    state_nxt = IDLE;
                end else begin
                    result_nxt = SUM_W'(sel_val);
                    idx_nxt    = idx_q + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Frame bookkeeping, accumulated sum and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            desc_q <= 1'b0;
            sum_q  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            err    <= err_nxt;
            result <= result_nxt;
            idx_q  <= idx_nxt;
            if (start) begin
                n_q    <= data_num;
                desc_q <= desc;
            end
            if (accept) begin
                sum_q <= sum_add;
                cnt_q <= cnt_eff + 4'd1;
            end
        end
    end

    // Sorted sample storage; contents are only meaningful below cnt_q, so no reset.
    always_ff @(posedge clk) begin
        if (accept) sbuf <= nbuf;
    end

    assign busy      = (state != IDLE);
    assign out_valid = state inside {OUT_SUM, OUT_MIN, OUT_MAX, OUT_DATA};

endmodule

// File: tb/tb_sort_stat_engine.sv
module tb_sort_stat_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  data_num;
    logic        desc;
    logic [7:0]  data_in;
    logic        busy;
    logic        out_valid;
    logic [11:0] result;
    logic        err;

    int checks = 0;
    int errors = 0;

    sort_stat_engine #(.DATA_W(8), .MAX_N(8), .SUM_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_num  (data_num),
        .desc      (desc),
        .data_in   (data_in),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              d;
        logic [3:0]        n;
        logic [1:0]        gap;
        logic [0:7][7:0]   s;
        logic [0:10][11:0] e;
    } vec_t;

    vec_t vt [6];
    vec_t tmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; non-first samples carry junk data_num/desc which must be ignored.
    task automatic send(input vec_t v);
        for (int i = 0; i < int'(v.n); i++) begin
            in_valid = 1'b1;
            data_num = (i == 0) ? v.n : 4'd0;
            desc     = (i == 0) ? v.d : ~v.d;
            data_in  = v.s[i];
            step();
            if (i == 0) chk("busy_first", busy, 1);
            if (i < int'(v.n) - 1) begin
                in_valid = 1'b0;
                data_in  = 8'hAA;
                for (int g = 0; g < int'(v.gap); g++) begin
                    step();
                    chk("gap_no_ovalid", out_valid, 0);
                end
            end
        end
        in_valid = 1'b0;
        data_num = 4'd0;
        chk("latency", out_valid, 1);
    endtask

    // Records the out_valid burst (bounded) and compares it with the expected stream.
    task automatic collect(input int n, input logic [0:10][11:0] e, input string tag);
        logic [11:0] got [11];
        int k = 0;
        while (out_valid === 1'b1 && k < 20) begin
            if (k < 11) got[k] = result;
            chk($sformatf("%s_busy_out", tag), busy, 1);
            step();
            k++;
        end
        chk($sformatf("%s_len", tag), k, n + 3);
        for (int j = 0; j < n + 3 && j < k && j < 11; j++)
            chk($sformatf("%s_res%0d", tag, j), got[j], e[j]);
        chk($sformatf("%s_busy_end", tag), busy, 0);
        chk($sformatf("%s_hold", tag), result, e[n+2]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{d:1'b0, n:4'd5, gap:2'd0,
                  s:{8'd7, 8'd3, 8'd9, 8'd3, 8'd1, 24'd0},
                  e:{12'd23, 12'd1, 12'd9, 12'd1, 12'd3, 12'd3, 12'd7, 12'd9, 36'd0}};
        vt[1] = '{d:1'b1, n:4'd4, gap:2'd2,
                  s:{8'd10, 8'd200, 8'd0, 8'd200, 32'd0},
                  e:{12'd410, 12'd0, 12'd200, 12'd200, 12'd200, 12'd10, 12'd0, 48'd0}};
        vt[2] = '{d:1'b0, n:4'd8, gap:2'd0,
                  s:{8{8'd255}},
                  e:{12'd2040, 12'd255, 12'd255, {8{12'd255}}}};
        vt[3] = '{d:1'b0, n:4'd1, gap:2'd0,
                  s:{8'd42, 56'd0},
                  e:{{4{12'd42}}, 84'd0}};
        vt[4] = '{d:1'b1, n:4'd6, gap:2'd1,
                  s:{8'd5, 8'd9, 8'd5, 8'd2, 8'd9, 8'd5, 16'd0},
                  e:{12'd35, 12'd2, 12'd9, 12'd9, 12'd9, 12'd5, 12'd5, 12'd5, 12'd2, 24'd0}};
        vt[5] = '{d:1'b0, n:4'd3, gap:2'd0,
                  s:{8'd255, 8'd0, 8'd128, 40'd0},
                  e:{12'd383, 12'd0, 12'd255, 12'd0, 12'd128, 12'd255, 60'd0}};

        rst = 1'b1; in_valid = 1'b0; data_num = 4'd0; desc = 1'b0; data_in = 8'd0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);

        // reset wins over a simultaneous frame start
        in_valid = 1'b1; data_num = 4'd2; data_in = 8'd9;
        step();
        chk("rst_prio_busy", busy, 0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            send(vt[v]);
            collect(int'(vt[v].n), vt[v].e, $sformatf("vec%0d", v));
            step();
        end

        // rejected frame lengths
        in_valid = 1'b1; data_num = 4'd0; data_in = 8'd11;
        step();
        chk("err0_pulse", err, 1);
        chk("err0_busy", busy, 0);
        chk("err0_ovalid", out_valid, 0);
        in_valid = 1'b0;
        step();
        chk("err0_clear", err, 0);
        in_valid = 1'b1; data_num = 4'd9;
        step();
        chk("err9_pulse", err, 1);
        chk("err9_busy", busy, 0);
        in_valid = 1'b0;
        step();
        chk("err9_clear", err, 0);
        chk("err9_ovalid", out_valid, 0);

        // reset during the data phase aborts the frame
        tmp = '{d:1'b0, n:4'd3, gap:2'd0, s:{8'd1, 8'd2, 8'd3, 40'd0}, e:'0};
        send(tmp);
        step(); step(); step();
        chk("abort_pre_ovalid", out_valid, 1);
        chk("abort_pre_data0", result, 1);
        rst = 1'b1;
        step();
        chk("abort_ovalid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        rst = 1'b0;
        step();
        tmp = '{d:1'b0, n:4'd2, gap:2'd0, s:{8'd5, 8'd4, 48'd0},
                e:{12'd9, 12'd4, 12'd5, 12'd4, 12'd5, 72'd0}};
        send(tmp);
        collect(2, tmp.e, "post_abort");
        step();

        // in_valid held high through the whole output phase
        tmp = '{d:1'b1, n:4'd3, gap:2'd0, s:{8'd4, 8'd8, 8'd6, 40'd0},
                e:{12'd18, 12'd4, 12'd8, 12'd8, 12'd6, 12'd4, 60'd0}};
        send(tmp);
        in_valid = 1'b1; data_num = 4'd2; desc = 1'b0; data_in = 8'd77;
        collect(3, tmp.e, "held");
        step();
        chk("held_new_busy", busy, 1);
        chk("held_new_ovalid", out_valid, 0);
        data_num = 4'd0; desc = 1'b1; data_in = 8'd6;
        step();
        in_valid = 1'b0;
        tmp.e = {12'd83, 12'd6, 12'd77, 12'd6, 12'd77, 72'd0};
        collect(2, tmp.e, "held_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_stat_engine.md
SORT_STAT_ENGINE -- requirements
Module: sort_stat_engine

Interface
REQ-001 Parameter DATA_W, default 8, bit width of each sample.
REQ-002 Parameter MAX_N, default 8, maximum samples per frame, legal range 2..15.
REQ-003 Parameter SUM_W, default DATA_W+4, width of result; SHALL be at least DATA_W+ceil(log2(MAX_N)).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  data_in (and data_num/desc on first sample) valid this cycle.
REQ-007 data_num  input  4  sample count of frame, sampled only with first in_valid of a frame.
REQ-008 desc  input  1  sort order, 0 ascending, 1 descending, sampled with data_num.
REQ-009 data_in  input  DATA_W  unsigned sample.
REQ-010 busy  output  1  high from first accepted sample until last output cycle inclusive.
REQ-011 out_valid  output  1  result valid this cycle.
REQ-012 result  output  SUM_W  sum, min, max, then sorted samples, zero-extended.
REQ-013 err  output  1  one-cycle pulse on rejected frame start.

Function
REQ-014 States IDLE, COLLECT, OUT_SUM, OUT_MIN, OUT_MAX, OUT_DATA; encoding free.
REQ-015 IDLE: in_valid with data_num in 2..MAX_N -> latch n=data_num, desc, store data_in as element 0, sum=data_in, go COLLECT.
REQ-016 IDLE: in_valid with data_num==1 -> n=1, go directly OUT_SUM next cycle with the single sample.
REQ-017 IDLE: in_valid with data_num==0 or >MAX_N -> sample dropped, err high next cycle for one cycle, stay IDLE.
REQ-018 COLLECT: each in_valid cycle inserts data_in into internal sorted buffer (single-cycle insertion), sum+=data_in; cycles with in_valid low hold all state (gaps allowed).
REQ-019 Insertion stable: a sample equal to stored values SHALL be placed after them.
REQ-020 Buffer order per latched desc: ascending for 0, descending for 1; unused slots never appear on result.
REQ-021 After the n-th accepted sample the next state is OUT_SUM; latency from n-th sample edge to first out_valid is one cycle.
REQ-022 OUT_SUM, OUT_MIN, OUT_MAX each last one cycle, result = sum, minimum, maximum respectively, independent of desc.
REQ-023 OUT_DATA lasts exactly n cycles, result = buffer element 0..n-1 in order, then IDLE.
REQ-024 out_valid high on exactly n+3 consecutive cycles per frame, low otherwise.
REQ-025 in_valid ignored (data dropped, no err) while in OUT_* states; new frame accepted in the first IDLE cycle after OUT_DATA.
REQ-026 Sum never overflows given REQ-003; no saturation logic.
REQ-027 data_num, desc changes outside first sample have no effect on the current frame.
REQ-028 result holds last driven value when out_valid low.

Reset
REQ-029 rst high at a clock edge -> state IDLE, busy=0, out_valid=0, err=0, result=0, sum=0, count=0, buffer contents don't-care.
REQ-030 rst mid-frame (any state) aborts frame; no partial output, next frame starts clean.
REQ-031 rst has priority over in_valid in the same cycle.

Verification
REQ-032 Ascending, n=5, samples 7,3,9,3,1 -> result 23,1,9,1,3,3,7,9 on 8 consecutive out_valid cycles.
REQ-033 Descending, n=4, samples 10,200,0,200 with in_valid gaps of 2 cycles -> 410,0,200,200,200,10,0.
REQ-034 n=MAX_N=8, all samples 255 -> sum 2040 (fits SUM_W=12), min 255, max 255, eight 255s.
REQ-035 data_num=0 then data_num=9 -> two err pulses, busy stays 0, no out_valid.
REQ-036 n=1, sample 42 -> 42,42,42,42; rst asserted during OUT_DATA of a second frame -> out_valid drops next cycle, following frame n=2 (5,4) -> 9,4,5,4,5.
REQ-037 in_valid held high through a whole output phase -> those samples ignored, next frame begins only after out_valid falls.
